// File: rtl/branch_trace_driver_if.sv
// Predictor update bus between the trace driver (master) and a branch predictor (slave).
// The predictor returns its prediction combinationally from PC.
interface branch_trace_driver_if;
  logic [31:0] PC;
  logic        update_en;
  logic        update_val;
  logic        prediction;

  modport master (
    output PC,
    output update_en,
    output update_val,
    input  prediction
  );

  modport slave (
    input  PC,
    input  update_en,
    input  update_val,
    output prediction
  );
endinterface

// File: rtl/branch_trace_driver.sv
// Replays a loaded trace of resolved branches into a predictor and counts mispredictions.
// Optional BRANCH_DRIVER_WARMUP_EN adds warmup_len: leading entries train but are not counted.
module branch_trace_driver #(
  parameter int unsigned TRACE_DEPTH = 1024,
  parameter int unsigned CNT_NBITS   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_en,
  input  logic [$clog2(TRACE_DEPTH)-1:0] load_addr,
  input  logic [31:0]                    load_pc,
  input  logic                           load_taken,
  input  logic [$clog2(TRACE_DEPTH):0]   trace_len,
`ifdef BRANCH_DRIVER_WARMUP_EN
  input  logic [$clog2(TRACE_DEPTH):0]   warmup_len,
`endif
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_NBITS-1:0]           branch_count,
  output logic [CNT_NBITS-1:0]           mispredict_count,
  branch_trace_driver_if.master          pred
);

  localparam int unsigned AddrW = $clog2(TRACE_DEPTH);
  localparam int unsigned LenW  = AddrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  state_e               state_q, state_d;
  logic [32:0]          mem [TRACE_DEPTH];
  logic [32:0]          entry_q;
  logic [AddrW-1:0]     ptr_q, ptr_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [LenW-1:0]      start_len;
  logic [CNT_NBITS-1:0] bcnt_q, bcnt_d;
  logic [CNT_NBITS-1:0] mcnt_q, mcnt_d;
  logic                 idle_like;
  logic                 last_entry;
  logic                 count_en;
  logic                 mismatch;

  assign idle_like  = (state_q == StIdle) || (state_q == StDone);
  assign start_len  = (trace_len > LenW'(TRACE_DEPTH)) ? LenW'(TRACE_DEPTH) : trace_len;
  assign last_entry = (LenW'(ptr_q) + LenW'(1)) == len_q;
  assign mismatch   = pred.prediction != entry_q[32];

`ifdef BRANCH_DRIVER_WARMUP_EN
  logic [LenW-1:0] warm_q, warm_d;

  // Entries with index below the latched warmup length only train the predictor.
  assign count_en = LenW'(ptr_q) >= warm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q <= '0;
    end else begin
      warm_q <= warm_d;
    end
  end

  always_comb begin
    warm_d = warm_q;
    if (idle_like && start) begin
      warm_d = warmup_len;
    end
  end
`else
  assign count_en = 1'b1;
`endif

  // Trace storage is never reset; writes are only accepted while not replaying.
  always_ff @(posedge clk) begin
    if (load_en && idle_like) begin
      mem[load_addr] <= {load_taken, load_pc};
    end
  end

  // The entry register doubles as the PC/update_val output register, so both hold
  // their last driven value outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else if (state_q == StFetch) begin
      entry_q <= mem[ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      len_q   <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          len_d   = start_len;
          ptr_d   = '0;
          bcnt_d  = '0;
          mcnt_d  = '0;
          state_d = (start_len == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        state_d = StExec;
      end
      StExec: begin
        ptr_d = ptr_q + AddrW'(1);
        if (count_en) begin
          bcnt_d = bcnt_q + CNT_NBITS'(1);
          mcnt_d = mcnt_q + CNT_NBITS'(mismatch);
        end
        state_d = last_entry ? StDone : StFetch;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign pred.PC          = entry_q[31:0];
  assign pred.update_val  = entry_q[32];
  assign pred.update_en   = (state_q == StExec);
  assign busy             = (state_q == StFetch) || (state_q == StExec);
  assign done             = (state_q == StDone);
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

endmodule
